// File: rtl/main_bus_burst_slave_pkg.sv
// Shared types and constants for the multiplexed main-bus burst slave.
package main_bus_burst_slave_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, RWAIT, READ} bus_state_t;

  localparam int   DEFAULT_BUSWIDTH = 16;
  localparam logic RW_READ          = 1'b1;
  localparam logic RW_WRITE         = 1'b0;

  // Counter width helper: a 1-entry range still needs a 1-bit vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/main_bus_burst_slave_if.sv
// Main-bus control/status bundle; AddrData is carried as a separate inout net.
interface main_bus_burst_slave_if #(
  parameter int BEAT_W = 2
);
  logic              AddrValid;
  logic              rw;
  logic              sel;
  logic              busy;
  logic [BEAT_W-1:0] beat;

  modport master (output AddrValid, rw, input sel, busy, beat);
  modport slave  (input AddrValid, rw, output sel, busy, beat);
endinterface

// File: rtl/main_bus_burst_slave_addr_gen.sv
// Burst address generator: latched word index, beat counter, wrap within aligned block.
module main_bus_burst_slave_addr_gen
  import main_bus_burst_slave_pkg::*;
#(
  parameter int  DEPTH     = 256,
  parameter int  BURST_LEN = 4,
  localparam int AW        = clog2_min1(DEPTH),
  localparam int BW        = clog2_min1(BURST_LEN)
) (
  input  logic          clk,
  input  logic          resetH,
  input  logic          load,
  input  logic [AW-1:0] idx_in,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic [BW-1:0] beat,
  output logic          last_beat
);

  localparam logic [AW-1:0] OFF_MASK = AW'(BURST_LEN - 1);

  logic [AW-1:0] idx_q, idx_d;
  logic [BW-1:0] beat_q, beat_d;

  always_comb begin
    idx_d  = idx_q;
    beat_d = beat_q;
    if (load) begin
      idx_d  = idx_in;
      beat_d = '0;
    end else if (advance) begin
      // Single-beat bursts keep the counter pinned at zero.
      beat_d = (BURST_LEN == 1) ? '0 : beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      idx_q  <= '0;
      beat_q <= '0;
    end else begin
      idx_q  <= idx_d;
      beat_q <= beat_d;
    end
  end

  // High bits from the aligned block base, low bits rotate by the beat count.
  assign addr      = (idx_q & ~OFF_MASK) | ((idx_q + AW'(beat_q)) & OFF_MASK);
  assign beat      = beat_q;
  assign last_beat = (beat_q == BW'(BURST_LEN - 1));

endmodule

// File: rtl/main_bus_burst_slave.sv
// Memory-side main-bus slave: window decode, wrapping fixed-length bursts, read wait states.
module main_bus_burst_slave
  import main_bus_burst_slave_pkg::*;
#(
  parameter int                  BUSWIDTH    = DEFAULT_BUSWIDTH,
  parameter int                  DEPTH       = 256,
  parameter int                  BURST_LEN   = 4,
  parameter int                  WAIT_STATES = 2,
  parameter logic [BUSWIDTH-1:0] BASE_ADDR   = 'h0100
) (
  input  logic                clk,
  input  logic                resetH,
  main_bus_burst_slave_if.slave bus,
  inout  wire  [BUSWIDTH-1:0] AddrData
);

  localparam int                  AW        = clog2_min1(DEPTH);
  localparam int                  BW        = clog2_min1(BURST_LEN);
  localparam int                  WC_W      = clog2_min1(WAIT_STATES);
  localparam logic [BUSWIDTH-1:0] ADDR_MASK = BUSWIDTH'(DEPTH - 1);

  bus_state_t state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;

  logic          hit, accept, load, advance, wr_en, last_beat, rd_oe;
  logic [AW-1:0] addr;
  logic [BW-1:0] beat;

  logic [BUSWIDTH-1:0] mem [DEPTH];

  assign hit    = (AddrData & ~ADDR_MASK) == BASE_ADDR;
  assign accept = (state_q == IDLE) && bus.AddrValid && hit;

  main_bus_burst_slave_addr_gen #(
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk       (clk),
    .resetH    (resetH),
    .load      (load),
    .idx_in    (AddrData[AW-1:0]),
    .advance   (advance),
    .addr      (addr),
    .beat      (beat),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    load    = 1'b0;
    advance = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (bus.rw == RW_WRITE) begin
            state_d = WRITE;
          end else begin
            state_d = RWAIT;
            wcnt_d  = WC_W'(WAIT_STATES - 1);
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        advance = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      RWAIT: begin
        if (wcnt_q == '0) state_d = READ;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      READ: begin
        advance = 1'b1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= AddrData;
  end

  // Drive only from the registered READ state, so WRITE beats can never collide.
  assign rd_oe    = (state_q == READ);
  assign AddrData = rd_oe ? mem[addr] : {BUSWIDTH{1'bz}};

  assign bus.sel  = accept || (state_q != IDLE);
  assign bus.busy = (state_q != IDLE);
  assign bus.beat = beat;

endmodule

// File: tb/tb_main_bus_burst_slave.sv
// Bench for main_bus_burst_slave: directed vector table, corner sequences, randomized bursts.
module tb_main_bus_burst_slave;
  import main_bus_burst_slave_pkg::*;

  localparam int          DEPTH = 256;
  localparam int          BL    = 4;
  localparam int          WS    = 2;
  localparam logic [15:0] BASE  = 16'h0100;

  logic clk = 1'b0;
  logic resetH;
  always #5 clk = ~clk;

  main_bus_burst_slave_if #(.BEAT_W(2)) bus ();

  wire  [15:0] ad;
  logic        m_oe;
  logic [15:0] m_data;
  assign ad = m_oe ? m_data : 16'hzzzz;
  wire bus_z = (ad === 16'hzzzz);

  main_bus_burst_slave #(
    .BUSWIDTH    (16),
    .DEPTH       (DEPTH),
    .BURST_LEN   (BL),
    .WAIT_STATES (WS),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .resetH   (resetH),
    .bus      (bus),
    .AddrData (ad)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] mm [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat k of a burst starting at word idx, wrapping inside its aligned block.
  function automatic int baddr(input int idx, input int k);
    return (idx - (idx % BL)) + ((idx + k) % BL);
  endfunction

  function automatic bit in_window(input logic [15:0] a);
    return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + DEPTH);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.AddrValid = 1'b0;
      m_oe = 1'b0;
      @(negedge clk);
      chk("idle_sel", bus.sel, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_beat", bus.beat, 0);
      chk("idle_bus_z", bus_z, 1);
      next_cycle();
    end
  endtask

  // d holds write data for writes, expected read data for reads (d[0] = beat 0).
  task automatic do_txn(input bit rd, input logic [15:0] addr, input logic [3:0][15:0] d,
                        input bit exp_hit, input bit ovl, input int rst_beat);
    int idx;
    idx = int'(addr) % DEPTH;
    bus.AddrValid = 1'b1;
    bus.rw = rd;
    m_oe = 1'b1;
    m_data = addr;
    @(negedge clk);
    chk("addr_sel", bus.sel, exp_hit);
    chk("addr_busy", bus.busy, 0);
    next_cycle();
    bus.AddrValid = 1'b0;
    if (!exp_hit) begin
      m_oe = 1'b0;
      return;
    end
    if (!rd) begin
      for (int k = 0; k < BL; k++) begin
        m_data = d[k];
        @(negedge clk);
        chk("wr_sel", bus.sel, 1);
        chk("wr_busy", bus.busy, 1);
        chk("wr_beat", bus.beat, k);
        next_cycle();
        mm[baddr(idx, k)] = d[k];
      end
      m_oe = 1'b0;
    end else begin
      m_oe = 1'b0;
      for (int w = 0; w < WS; w++) begin
        if (ovl && w == 0) begin
          bus.AddrValid = 1'b1;
          bus.rw = RW_WRITE;
          m_oe = 1'b1;
          m_data = 16'h0108;
        end
        @(negedge clk);
        chk("rwait_sel", bus.sel, 1);
        chk("rwait_busy", bus.busy, 1);
        chk("rwait_beat", bus.beat, 0);
        if (!(ovl && w == 0)) chk("rwait_bus_z", bus_z, 1);
        next_cycle();
        bus.AddrValid = 1'b0;
        m_oe = 1'b0;
      end
      for (int k = 0; k < BL; k++) begin
        resetH = (k == rst_beat);
        @(negedge clk);
        chk("rd_data", ad, d[k]);
        chk("rd_beat", bus.beat, k);
        chk("rd_busy", bus.busy, 1);
        next_cycle();
        if (k == rst_beat) begin
          resetH = 1'b0;
          @(negedge clk);
          chk("rst_busy", bus.busy, 0);
          chk("rst_beat", bus.beat, 0);
          chk("rst_sel", bus.sel, 0);
          chk("rst_bus_z", bus_z, 1);
          next_cycle();
          return;
        end
      end
    end
  endtask

  typedef struct {
    bit              rd;
    logic [15:0]     addr;
    logic [3:0][15:0] d;
    bit              hit;
    int              idle_after;
  } vec_t;

  localparam logic [15:0] A0 = 16'hA000, A1 = 16'hA111, A2 = 16'hA222, A3 = 16'hA333;
  localparam logic [15:0] B0 = 16'hB000, B1 = 16'hB111, B2 = 16'hB222, B3 = 16'hB333;
  localparam logic [15:0] C0 = 16'hC000, C1 = 16'hC111, C2 = 16'hC222, C3 = 16'hC333;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    logic [3:0][15:0] d;
    logic [15:0] a;
    bit rd;

    tab[0] = '{1'b0, 16'h0104, {A3, A2, A1, A0}, 1'b1, 0};
    tab[1] = '{1'b1, 16'h0106, {A1, A0, A3, A2}, 1'b1, 1};
    tab[2] = '{1'b1, 16'h0200, 64'h0,            1'b0, 9};
    tab[3] = '{1'b0, 16'h01F0, {B3, B2, B1, B0}, 1'b1, 0};
    tab[4] = '{1'b1, 16'h01F0, {B3, B2, B1, B0}, 1'b1, 2};
    tab[5] = '{1'b1, 16'h00FF, 64'h0,            1'b0, 1};
    tab[6] = '{1'b0, 16'h01FF, {C3, C2, C1, C0}, 1'b1, 0};
    tab[7] = '{1'b1, 16'h01FC, {C0, C3, C2, C1}, 1'b1, 1};

    resetH = 1'b1;
    bus.AddrValid = 1'b0;
    bus.rw = 1'b0;
    m_oe = 1'b0;
    m_data = 16'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("reset_sel", bus.sel, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_beat", bus.beat, 0);
    chk("reset_bus_z", bus_z, 1);
    next_cycle();
    resetH = 1'b0;
    idle_cycles(1);

    for (int i = 0; i < 8; i++) begin
      do_txn(tab[i].rd, tab[i].addr, tab[i].d, tab[i].hit, 1'b0, -1);
      idle_cycles(tab[i].idle_after);
    end

    // Address pulse during RWAIT must not disturb the running read.
    do_txn(1'b1, 16'h0104, {A3, A2, A1, A0}, 1'b1, 1'b1, -1);
    idle_cycles(1);
    // Reset on beat 1, then a fresh read starts from A0.
    do_txn(1'b1, 16'h0104, {A3, A2, A1, A0}, 1'b1, 1'b0, 1);
    do_txn(1'b1, 16'h0104, {A3, A2, A1, A0}, 1'b1, 1'b0, -1);
    idle_cycles(1);

    for (int b = 0; b < DEPTH / BL; b++) begin
      for (int k = 0; k < BL; k++) d[k] = 16'($urandom);
      do_txn(1'b0, 16'(int'(BASE) + b * BL), d, 1'b1, 1'b0, -1);
    end
    idle_cycles(1);

    for (int t = 0; t < 60; t++) begin
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = 16'(int'(BASE) + $urandom_range(0, DEPTH - 1));
      else                           a = 16'($urandom);
      if (rd) begin
        for (int k = 0; k < BL; k++) d[k] = mm[baddr(int'(a) % DEPTH, k)];
      end else begin
        for (int k = 0; k < BL; k++) d[k] = 16'($urandom);
      end
      do_txn(rd, a, d, in_window(a), 1'b0, -1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
